button_conditioner: RTL and testbench

//  N-channel push-button front end: synchronise, debounce, classify each raw button.

---
 rtl/button_conditioner_pkg.sv | 18 +
 rtl/button_conditioner_if.sv | 23 ++
 rtl/button_conditioner_channel.sv | 188 ++++++++++++++++++
 rtl/button_conditioner.sv | 55 +++++
 tb/tb_button_conditioner.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/button_conditioner_pkg.sv
// Shared types for the button conditioner: per-channel FSM state encoding and counter sizing.
// Optional feature macro used by this slice: BTN_AUTO_REPEAT_EN.
package btn_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DEB_DN = 3'd1,
    HELD   = 3'd2,
    LONG   = 3'd3,
    DEB_UP = 3'd4
  } btn_state_t;

  // Bits needed to hold 0..max_val inclusive.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button conditioner bus: raw inputs and enable in, conditioned levels and strobes out.
// Optional feature macro: BTN_AUTO_REPEAT_EN (repeat_pulse stays 0 when undefined).
interface button_conditioner_if #(
  parameter int unsigned N_CH = 4
);
  logic            ena;
  logic [N_CH-1:0] btn_raw;
  logic [N_CH-1:0] btn_level;
  logic [N_CH-1:0] press_pulse;
  logic [N_CH-1:0] release_pulse;
  logic [N_CH-1:0] long_pulse;
  logic [N_CH-1:0] repeat_pulse;

  modport master (
    output ena, btn_raw,
    input  btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse
  );

  modport slave (
    input  ena, btn_raw,
    output btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse
  );
endinterface

// File: rtl/button_conditioner_channel.sv
// One button: synchroniser, debounce/hold FSM and saturating counters; all outputs registered.
// Auto-repeat strobe and its counter exist only when BTN_AUTO_REPEAT_EN is defined.
module btn_channel
  import btn_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DEBOUNCE_CYC = 16,
  parameter int unsigned LONG_CYC     = 1000,
  parameter int unsigned REPEAT_CYC   = 200,
  parameter logic        INVERT       = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_ena,
  input  logic i_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long,
  output logic o_repeat
);

  if (SYNC_STAGES < 2 || DEBOUNCE_CYC < 1 || LONG_CYC <= DEBOUNCE_CYC || REPEAT_CYC < 1) begin : g_bad_cfg
    $error("btn_channel: invalid parameter set");
  end

  localparam int unsigned DW = cnt_w(DEBOUNCE_CYC);
  localparam int unsigned HW = cnt_w(LONG_CYC);
  localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE_CYC);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYC - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  btn_state_t             r_state, w_state_nx;
  logic [DW-1:0]          r_deb, w_deb_nx, w_deb_inc;
  logic [HW-1:0]          r_hold, w_hold_nx, w_hold_inc;
  logic                   r_long_seen, w_long_seen_nx;
  logic                   r_level, w_level_nx;
  logic                   r_press, w_press_nx;
  logic                   r_release, w_release_nx;
  logic                   r_long, w_long_nx;
  logic                   w_s;

`ifdef BTN_AUTO_REPEAT_EN
  localparam int unsigned RW = cnt_w(REPEAT_CYC);
  localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYC - 1);
  logic [RW-1:0] r_rpt, w_rpt_nx;
  logic          r_repeat, w_repeat_nx;
`endif

  // The synchroniser keeps sampling while ena is low so no stale level is seen on resume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
  end

  assign w_s        = r_sync[SYNC_STAGES-1] ^ INVERT;
  assign w_deb_inc  = (r_deb == DEB_MAX) ? r_deb : r_deb + DW'(1);
  assign w_hold_inc = (r_hold == HOLD_LAST) ? r_hold : r_hold + HW'(1);

  always_comb begin
    w_state_nx     = r_state;
    w_deb_nx       = r_deb;
    w_hold_nx      = r_hold;
    w_long_seen_nx = r_long_seen;
    w_level_nx     = r_level;
    w_press_nx     = 1'b0;
    w_release_nx   = 1'b0;
    w_long_nx      = 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
    w_rpt_nx       = r_rpt;
    w_repeat_nx    = 1'b0;
`endif
    if (i_ena) begin
      unique case (r_state)
        IDLE: begin
          if (w_s) begin
            w_state_nx = DEB_DN;
            w_deb_nx   = DW'(1);
          end
        end
        DEB_DN: begin
          if (!w_s) begin
            w_state_nx = IDLE;
          end else if (r_deb == DEB_MAX) begin
            w_state_nx = HELD;
            w_level_nx = 1'b1;
            w_press_nx = 1'b1;
            w_hold_nx  = '0;
          end else begin
            w_deb_nx = w_deb_inc;
          end
        end
        HELD: begin
          if (!w_s) begin
            w_state_nx     = DEB_UP;
            w_deb_nx       = DW'(1);
            w_long_seen_nx = 1'b0;
            w_hold_nx      = w_hold_inc;
          end else if (r_hold == HOLD_LAST) begin
            w_state_nx = LONG;
            w_long_nx  = 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
            w_rpt_nx   = '0;
`endif
          end else begin
            w_hold_nx = w_hold_inc;
          end
        end
        LONG: begin
          if (!w_s) begin
            w_state_nx     = DEB_UP;
            w_deb_nx       = DW'(1);
            w_long_seen_nx = 1'b1;
          end else begin
`ifdef BTN_AUTO_REPEAT_EN
            if (r_rpt == RPT_LAST) begin
              w_rpt_nx    = '0;
              w_repeat_nx = 1'b1;
            end else begin
              w_rpt_nx = r_rpt + RW'(1);
            end
`endif
          end
        end
        DEB_UP: begin
          // hold_cnt keeps running through a release bounce; saturated once LONG was reached.
          w_hold_nx = w_hold_inc;
          if (w_s) begin
            w_state_nx = r_long_seen ? LONG : HELD;
          end else if (r_deb == DEB_MAX) begin
            w_state_nx   = IDLE;
            w_level_nx   = 1'b0;
            w_release_nx = 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
            w_rpt_nx     = '0;
`endif
          end else begin
            w_deb_nx = w_deb_inc;
          end
        end
        default: w_state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_deb       <= '0;
      r_hold      <= '0;
      r_long_seen <= 1'b0;
      r_level     <= 1'b0;
      r_press     <= 1'b0;
      r_release   <= 1'b0;
      r_long      <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_deb       <= w_deb_nx;
      r_hold      <= w_hold_nx;
      r_long_seen <= w_long_seen_nx;
      r_level     <= w_level_nx;
      r_press     <= w_press_nx;
      r_release   <= w_release_nx;
      r_long      <= w_long_nx;
    end
  end

`ifdef BTN_AUTO_REPEAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rpt    <= '0;
      r_repeat <= 1'b0;
    end else begin
      r_rpt    <= w_rpt_nx;
      r_repeat <= w_repeat_nx;
    end
  end
  assign o_repeat = r_repeat;
`else
  assign o_repeat = 1'b0;
`endif

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_long    = r_long;

endmodule

// File: rtl/button_conditioner.sv
// N-channel push-button front end: reset synchroniser plus one btn_channel per button.
// Define BTN_AUTO_REPEAT_EN to enable the auto-repeat strobe.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned     N_CH         = 4,
  parameter int unsigned     SYNC_STAGES  = 2,
  parameter int unsigned     DEBOUNCE_CYC = 16,
  parameter int unsigned     LONG_CYC     = 1000,
  parameter int unsigned     REPEAT_CYC   = 200,
  parameter logic [N_CH-1:0] INVERT       = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  button_conditioner_if.slave  bus
);

  logic [1:0]      r_rst_pipe;
  logic            w_rst_n;
  logic [N_CH-1:0] w_level, w_press, w_release, w_long, w_repeat;

  // Reset asserts asynchronously and releases on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_pipe <= '0;
    else        r_rst_pipe <= {r_rst_pipe[0], 1'b1};
  end
  assign w_rst_n = r_rst_pipe[1];

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    btn_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .LONG_CYC     (LONG_CYC),
      .REPEAT_CYC   (REPEAT_CYC),
      .INVERT       (INVERT[gi])
    ) u_ch (
      .clk       (clk),
      .rst_n     (w_rst_n),
      .i_ena     (bus.ena),
      .i_raw     (bus.btn_raw[gi]),
      .o_level   (w_level[gi]),
      .o_press   (w_press[gi]),
      .o_release (w_release[gi]),
      .o_long    (w_long[gi]),
      .o_repeat  (w_repeat[gi])
    );
  end

  assign bus.btn_level     = w_level;
  assign bus.press_pulse   = w_press;
  assign bus.release_pulse = w_release;
  assign bus.long_pulse    = w_long;
  assign bus.repeat_pulse  = w_repeat;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner (N_CH=4, SYNC=2, DEB=4, LONG=20, REPEAT=8).
// Expected repeat strobes depend on BTN_AUTO_REPEAT_EN.
module tb_button_conditioner;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  prs;
    logic [3:0]  rel;
    logic [3:0]  lng;
    logic [3:0]  rpt;
    logic [3:0]  lvl;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  ev_t         sb[$];
  int unsigned t0;

  button_conditioner_if #(.N_CH(4)) bus ();

  button_conditioner #(
    .N_CH         (4),
    .SYNC_STAGES  (2),
    .DEBOUNCE_CYC (4),
    .LONG_CYC     (20),
    .REPEAT_CYC   (8),
    .INVERT       (4'b0000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int unsigned c, input logic [3:0] p, input logic [3:0] r,
                      input logic [3:0] l, input logic [3:0] rp, input logic [3:0] lv);
    ev_t e;
    e.cyc = c; e.prs = p; e.rel = r; e.lng = l; e.rpt = rp; e.lvl = lv;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every cycle carrying a strobe must match the next scoreboard entry.
  always @(negedge clk) begin
    ev_t e;
    if (|{bus.press_pulse, bus.release_pulse, bus.long_pulse, bus.repeat_pulse}) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pulse: got prs=%b rel=%b lng=%b rpt=%b at cyc %0d, expected none",
                 bus.press_pulse, bus.release_pulse, bus.long_pulse, bus.repeat_pulse, cyc);
      end else begin
        e = sb.pop_front();
        check("pulse_cycle", cyc, e.cyc);
        check("pulse_vec",
              {12'h0, bus.press_pulse, bus.release_pulse, bus.long_pulse, bus.repeat_pulse, bus.btn_level},
              {12'h0, e.prs, e.rel, e.lng, e.rpt, e.lvl});
      end
    end
  end

  initial begin
    bus.ena     = 1'b1;
    bus.btn_raw = 4'hF;

    // 1: reset with all raw inputs active
    tick(4);
    check("rst_level",   {28'h0, bus.btn_level},     32'h0);
    check("rst_press",   {28'h0, bus.press_pulse},   32'h0);
    check("rst_release", {28'h0, bus.release_pulse}, 32'h0);
    check("rst_long",    {28'h0, bus.long_pulse},    32'h0);
    check("rst_repeat",  {28'h0, bus.repeat_pulse},  32'h0);
    rst_n       = 1'b1;
    bus.btn_raw = 4'h0;
    tick(8);
    check("post_rst_level", {28'h0, bus.btn_level}, 32'h0);

    // 2: clean press on ch0, 12 cycles
    bus.btn_raw = 4'b0001;
    t0 = cyc + 1;
    push(t0 + 6,  4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
    push(t0 + 18, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    tick(12);
    bus.btn_raw = 4'b0000;
    check("t2_level_held", {28'h0, bus.btn_level}, 32'h1);
    tick(12);
    check("t2_level_rel", {28'h0, bus.btn_level}, 32'h0);
    check("t2_sb_empty", sb.size(), 0);
    tick(6);

    // 3: bounce on ch1, never four stable cycles
    for (int i = 0; i < 5; i++) begin
      bus.btn_raw = 4'b0010;
      tick(3);
      bus.btn_raw = 4'b0000;
      tick(1);
    end
    tick(12);
    check("t3_level", {28'h0, bus.btn_level}, 32'h0);
    check("t3_sb_empty", sb.size(), 0);

    // 4: long hold on ch2, 45 cycles
    bus.btn_raw = 4'b0100;
    t0 = cyc + 1;
    push(t0 + 6,  4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100);
    push(t0 + 26, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0100);
`ifdef BTN_AUTO_REPEAT_EN
    push(t0 + 34, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
    push(t0 + 42, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
`endif
    push(t0 + 51, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
    tick(45);
    bus.btn_raw = 4'b0000;
    check("t4_level_held", {28'h0, bus.btn_level}, 32'h4);
    tick(12);
    check("t4_sb_empty", sb.size(), 0);
    tick(4);

    // 5: ch0+ch3 together, ena low for three cycles mid-debounce
    bus.btn_raw = 4'b1001;
    t0 = cyc + 1;
    push(t0 + 9,  4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b1001);
    push(t0 + 18, 4'b0000, 4'b1001, 4'b0000, 4'b0000, 4'b0000);
    tick(3);
    bus.ena = 1'b0;
    tick(3);
    bus.ena = 1'b1;
    check("t5_level_prepress", {28'h0, bus.btn_level}, 32'h0);
    tick(6);
    bus.btn_raw = 4'b0000;
    check("t5_level_held", {28'h0, bus.btn_level}, 32'h9);
    tick(12);
    check("t5_sb_empty", sb.size(), 0);
    tick(4);

    // 6: reset while ch0 is held; release happens inside reset
    bus.btn_raw = 4'b0001;
    t0 = cyc + 1;
    push(t0 + 6, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
    tick(10);
    check("t6_level_before", {28'h0, bus.btn_level}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("t6_level_async", {28'h0, bus.btn_level}, 32'h0);
    bus.btn_raw = 4'b0000;
    tick(2);
    rst_n = 1'b1;
    tick(25);
    check("t6_level_after", {28'h0, bus.btn_level}, 32'h0);
    check("t6_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
